// File: rtl/ccd_capture.sv
// ccd_capture: front-end capture stage for the D5M camera path.
// Registers raw Bayer pixels and line-valid from the sensor clock domain,
// accepts or rejects whole frames under host start/stop control and
// produces a pixel-valid strobe with column/line coordinates and a count
// of accepted frames.
module ccd_capture #(
  parameter int unsigned COLUMN_WIDTH = 1280
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [11:0] iDATA,
  input  logic        iFVAL,
  input  logic        iLVAL,
  input  logic        iSTART,
  input  logic        iEND,
  output logic [11:0] oDATA,
  output logic        oDVAL,
  output logic [15:0] oX_Cont,
  output logic [15:0] oY_Cont,
  output logic [31:0] oFrame_Cont
);

  // Last column index before the X counter wraps to the next line.
  localparam logic [15:0] COL_LAST = 16'(COLUMN_WIDTH - 1);

  // Registered state
  logic        start_r;       // host capture enable, sticky between iSTART/iEND
  logic        fval_prev_r;   // raw iFVAL from the previous edge, for edge detect
  logic        fval_r;        // gated frame-valid: high only inside accepted frames
  logic        lval_r;        // registered line-valid
  logic [11:0] data_r;        // registered pixel data
  logic [15:0] x_cont_r;
  logic [15:0] y_cont_r;
  logic [31:0] frame_cont_r;

  // Next-state values
  logic        start_s;
  logic        frame_rise_s;
  logic        frame_fall_s;
  logic        accept_s;
  logic        fval_s;
  logic [15:0] x_cont_s;
  logic [15:0] y_cont_s;
  logic [31:0] frame_cont_s;

  // Start flag: iSTART has priority over iEND; otherwise the flag holds.
  always_comb begin
    start_s = start_r;
    if (iSTART) begin
      start_s = 1'b1;
    end else if (iEND) begin
      start_s = 1'b0;
    end else begin
      start_s = start_r;
    end
  end

  // Frame gating: a frame is accepted only on its rising edge while the
  // (already registered) start flag is set, and always ends on the falling
  // edge, so dropping the start flag mid-frame never truncates a frame.
  always_comb begin
    frame_rise_s = ~fval_prev_r & iFVAL;
    frame_fall_s = fval_prev_r & ~iFVAL;
    accept_s     = frame_rise_s & start_r;
    fval_s       = fval_r;
    if (accept_s) begin
      fval_s = 1'b1;
    end else if (frame_fall_s) begin
      fval_s = 1'b0;
    end else begin
      fval_s = fval_r;
    end
  end

  // Pixel coordinates advance on the registered line-valid so that the
  // count shown alongside a valid pixel on oDATA is that pixel's own index.
  // Short lines leave X where it stopped; only a full line wraps X.
  always_comb begin
    x_cont_s = x_cont_r;
    y_cont_s = y_cont_r;
    if (fval_r) begin
      if (lval_r) begin
        if (x_cont_r == COL_LAST) begin
          x_cont_s = 16'd0;
          y_cont_s = y_cont_r + 16'd1;
        end else begin
          x_cont_s = x_cont_r + 16'd1;
          y_cont_s = y_cont_r;
        end
      end else begin
        x_cont_s = x_cont_r;
        y_cont_s = y_cont_r;
      end
    end else begin
      x_cont_s = 16'd0;
      y_cont_s = 16'd0;
    end
  end

  // Frame counter counts exactly the rising edges that open a gated frame.
  always_comb begin
    frame_cont_s = frame_cont_r;
    if (accept_s) begin
      frame_cont_s = frame_cont_r + 32'd1;
    end else begin
      frame_cont_s = frame_cont_r;
    end
  end

  // Control state registers: start flag, iFVAL history and gated frame-valid.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      start_r     <= 1'b0;
      fval_prev_r <= 1'b0;
      fval_r      <= 1'b0;
    end else begin
      start_r     <= start_s;
      fval_prev_r <= iFVAL;
      fval_r      <= fval_s;
    end
  end

  // Pixel path registers: data and line-valid sampled every cycle.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      data_r <= 12'd0;
      lval_r <= 1'b0;
    end else begin
      data_r <= iDATA;
      lval_r <= iLVAL;
    end
  end

  // Coordinate and frame counters.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      x_cont_r     <= 16'd0;
      y_cont_r     <= 16'd0;
      frame_cont_r <= 32'd0;
    end else begin
      x_cont_r     <= x_cont_s;
      y_cont_r     <= y_cont_s;
      frame_cont_r <= frame_cont_s;
    end
  end

  assign oDATA       = data_r;
  assign oDVAL       = fval_r & lval_r;
  assign oX_Cont     = x_cont_r;
  assign oY_Cont     = y_cont_r;
  assign oFrame_Cont = frame_cont_r;

endmodule

// File: tb/tb_ccd_capture.sv
// Directed testbench for ccd_capture with COLUMN_WIDTH = 4.
module tb_ccd_capture;

  logic        iCLK;
  logic        iRST;
  logic [11:0] iDATA;
  logic        iFVAL;
  logic        iLVAL;
  logic        iSTART;
  logic        iEND;
  logic [11:0] oDATA;
  logic        oDVAL;
  logic [15:0] oX_Cont;
  logic [15:0] oY_Cont;
  logic [31:0] oFrame_Cont;

  int checks_cnt;
  int errors_cnt;
  int dval_seen;

  ccd_capture #(.COLUMN_WIDTH(4)) dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iDATA       (iDATA),
    .iFVAL       (iFVAL),
    .iLVAL       (iLVAL),
    .iSTART      (iSTART),
    .iEND        (iEND),
    .oDATA       (oDATA),
    .oDVAL       (oDVAL),
    .oX_Cont     (oX_Cont),
    .oY_Cont     (oY_Cont),
    .oFrame_Cont (oFrame_Cont)
  );

  // 10 ns pixel clock
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Single comparison point: count and report.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one pixel-clock cycle of sensor inputs; return 1 ns after the edge.
  task automatic cyc(input logic f, input logic l, input logic [11:0] d);
    @(negedge iCLK);
    iFVAL = f;
    iLVAL = l;
    iDATA = d;
    @(posedge iCLK);
    #1;
    if (oDVAL === 1'b1) dval_seen++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},  {20'd0, oDATA}, 32'd0);
    check({tag, "_dval"},  {31'd0, oDVAL}, 32'd0);
    check({tag, "_x"},     {16'd0, oX_Cont}, 32'd0);
    check({tag, "_y"},     {16'd0, oY_Cont}, 32'd0);
    check({tag, "_frame"}, oFrame_Cont, 32'd0);
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    dval_seen  = 0;
    iRST   = 1'b0;
    iSTART = 1'b0;
    iEND   = 1'b0;
    iFVAL  = 1'b0;
    iLVAL  = 1'b0;
    iDATA  = 12'd0;

    // Reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      @(negedge iCLK);
      iDATA  = 12'($urandom);
      iFVAL  = 1'($urandom);
      iLVAL  = 1'($urandom);
      iSTART = 1'($urandom);
      iEND   = 1'($urandom);
    end
    @(posedge iCLK);
    #1;
    check_all_zero("reset");

    // Release with start disabled: three frames rejected
    @(negedge iCLK);
    iSTART = 1'b0;
    iEND   = 1'b0;
    iFVAL  = 1'b0;
    iLVAL  = 1'b0;
    iRST   = 1'b1;
    dval_seen = 0;
    for (int f = 0; f < 3; f++) begin
      cyc(1'b1, 1'b0, 12'h000);
      cyc(1'b1, 1'b1, 12'h111);
      cyc(1'b1, 1'b1, 12'h222);
      cyc(1'b0, 1'b0, 12'h000);
      cyc(1'b0, 1'b0, 12'h000);
    end
    check("nostart_dval", dval_seen, 32'd0);
    check("nostart_frame", oFrame_Cont, 32'd0);

    // One-cycle start pulse, then a frame of 3 lines x 4 pixels with gaps
    iSTART = 1'b1;
    cyc(1'b0, 1'b0, 12'h000);
    iSTART = 1'b0;
    for (int l = 0; l < 3; l++) begin
      for (int c = 0; c < 4; c++) begin
        cyc(1'b1, 1'b1, 12'(l * 4 + c));
        check("pix_data", {20'd0, oDATA}, 32'(l * 4 + c));
        check("pix_dval", {31'd0, oDVAL}, 32'd1);
        check("pix_x", {16'd0, oX_Cont}, 32'(c));
        check("pix_y", {16'd0, oY_Cont}, 32'(l));
        if (l == 0 && c == 0) check("first_frame", oFrame_Cont, 32'd1);
      end
      if (l < 2) begin
        // stop request during the first gap must not cut the frame
        if (l == 0) iEND = 1'b1;
        for (int g = 0; g < 5; g++) begin
          cyc(1'b1, 1'b0, 12'h5A5);
          check("gap_dval", {31'd0, oDVAL}, 32'd0);
          check("gap_x", {16'd0, oX_Cont}, 32'd0);
          check("gap_y", {16'd0, oY_Cont}, 32'(l + 1));
        end
        check("gap_data", {20'd0, oDATA}, 32'h5A5);
        iEND = 1'b0;
      end
    end
    cyc(1'b1, 1'b0, 12'h000);
    cyc(1'b0, 1'b0, 12'h000);
    cyc(1'b0, 1'b0, 12'h000);
    check("post_x", {16'd0, oX_Cont}, 32'd0);
    check("post_y", {16'd0, oY_Cont}, 32'd0);
    check("post_dval", {31'd0, oDVAL}, 32'd0);

    // Next frame rejected; iSTART raised mid-frame must not open it
    dval_seen = 0;
    cyc(1'b1, 1'b1, 12'h001);
    cyc(1'b1, 1'b1, 12'h002);
    iSTART = 1'b1;
    cyc(1'b1, 1'b1, 12'h003);
    cyc(1'b1, 1'b1, 12'h004);
    cyc(1'b0, 1'b0, 12'h000);
    check("reject_dval", dval_seen, 32'd0);
    check("reject_frame", oFrame_Cont, 32'd1);

    // Three more accepted frames with iSTART held
    cyc(1'b0, 1'b0, 12'h000);
    for (int f = 0; f < 3; f++) begin
      cyc(1'b1, 1'b1, 12'(12'h100 + f));
      check("acc_dval", {31'd0, oDVAL}, 32'd1);
      check("acc_x0", {16'd0, oX_Cont}, 32'd0);
      cyc(1'b1, 1'b1, 12'h0FF);
      check("acc_x1", {16'd0, oX_Cont}, 32'd1);
      cyc(1'b0, 1'b0, 12'h000);
      cyc(1'b0, 1'b0, 12'h000);
    end
    check("frame_count4", oFrame_Cont, 32'd4);

    // Reset in the middle of a frame (pixel 2 of line 1)
    for (int k = 0; k < 6; k++) cyc(1'b1, 1'b1, 12'(k));
    check("pre_rst_frame", oFrame_Cont, 32'd5);
    @(negedge iCLK);
    iDATA = 12'h006;
    #2;
    iRST = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge iCLK);
    iRST = 1'b1;
    dval_seen = 0;
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 12'(7 + k));
    check("after_rst_dval", dval_seen, 32'd0);
    check("after_rst_frame", oFrame_Cont, 32'd0);
    cyc(1'b0, 1'b0, 12'h000);
    cyc(1'b1, 1'b1, 12'h009);
    check("restart_dval", {31'd0, oDVAL}, 32'd1);
    check("restart_frame", oFrame_Cont, 32'd1);
    check("restart_data", {20'd0, oDATA}, 32'h009);
    check("restart_x", {16'd0, oX_Cont}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
